// File: rtl/stage2_conv_ctrl.sv
// Frame sequencer for the stage-2 conv core. Optional drain watchdog: define ST2_CTRL_TIMEOUT_EN.
// Latency: first read 1 cycle after i_start, o_core_valid trails o_rd_en by RD_LAT, o_done 1 cycle after last count.
// Backpressure: i_hold (sampled at an edge) suppresses the next cycle's read; i_start is ignored while busy.
module stage2_conv_ctrl #(
  parameter int COL     = 12,
  parameter int ROW     = 12,
  parameter int K       = 5,
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_start,
  input  logic                       i_hold,
  output logic                       o_rd_en,
  output logic [$clog2(COL*ROW)-1:0] o_rd_addr,
  output logic                       o_core_valid,
  input  logic                       i_core_ot_valid,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_err,
  output logic [7:0]                 o_frame_cnt
);

  localparam int NPIX    = COL * ROW;
  localparam int AW      = $clog2(NPIX);
  localparam int OUT_CNT = (COL - K + 1) * (ROW - K + 1);
  localparam int OW      = $clog2(OUT_CNT + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
  localparam logic [OW-1:0] OUT_FULL  = OW'(OUT_CNT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [OW-1:0]     out_cnt, out_cnt_nxt;
  logic [RD_LAT-1:0] vld_sr;
  logic              last_issue;
  logic              cnt_full;
  logic              wd_expire;
  logic              rd_en_nxt;
  logic [AW-1:0]     rd_addr_nxt;
  logic              busy_nxt;
  logic              done_nxt;
  logic [7:0]        frame_cnt_nxt;

  // The read being presented this cycle is the final pixel of the frame.
  assign last_issue = o_rd_en && (o_rd_addr == LAST_ADDR);
  // True when the output count (including this cycle's valid) completes the frame.
  assign cnt_full   = (out_cnt_nxt == OUT_FULL);
  assign o_core_valid = vld_sr[RD_LAT-1];

`ifdef ST2_CTRL_TIMEOUT_EN
  logic [7:0] wd_cnt, wd_cnt_nxt;
  logic       err_nxt;

  // Watchdog expires on the TIMEOUT-th consecutive DRAIN cycle without a core output.
  assign wd_expire = (state == S_DRAIN) && !i_core_ot_valid && (wd_cnt == 8'(TIMEOUT - 1));

  // Watchdog count: zero outside DRAIN (so it is clear on entry), restarts on every output valid.
  always_comb begin
    wd_cnt_nxt = '0;
    if (state == S_DRAIN && !i_core_ot_valid) wd_cnt_nxt = wd_cnt + 8'd1;
  end

  // Error flag: set on watchdog expiry, held until the next accepted start.
  always_comb begin
    err_nxt = o_err;
    if (state == S_IDLE && i_start)   err_nxt = 1'b0;
    else if (wd_expire && !cnt_full)  err_nxt = 1'b1;
  end

  // Watchdog and error registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
      o_err  <= 1'b0;
    end else begin
      wd_cnt <= wd_cnt_nxt;
      o_err  <= err_nxt;
    end
  end
`else
  // No watchdog: DRAIN waits indefinitely and the error flag is constant low.
  assign wd_expire = 1'b0;
  assign o_err     = 1'b0 & (TIMEOUT == 0);
`endif

  // Output counter: cleared in IDLE, counts core outputs in STREAM/DRAIN, saturates at OUT_CNT.
  always_comb begin
    out_cnt_nxt = out_cnt;
    if (state == S_IDLE) begin
      out_cnt_nxt = '0;
    end else if ((state == S_STREAM || state == S_DRAIN) && i_core_ot_valid && (out_cnt != OUT_FULL)) begin
      out_cnt_nxt = out_cnt + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (i_start) state_nxt = S_STREAM;
      S_STREAM: if (last_issue) state_nxt = S_DRAIN;
      S_DRAIN:  if (cnt_full || wd_expire) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Next values for the registered outputs, derived from the current state and inputs.
  always_comb begin
    rd_en_nxt     = 1'b0;
    rd_addr_nxt   = o_rd_addr;
    busy_nxt      = (state_nxt != S_IDLE);
    done_nxt      = (state_nxt == S_DONE);
    frame_cnt_nxt = o_frame_cnt;
    case (state)
      S_IDLE: begin
        rd_addr_nxt = '0;
        if (i_start) rd_en_nxt = 1'b1;
      end
      S_STREAM: begin
        if (last_issue) begin
          rd_addr_nxt = '0;
        end else begin
          rd_en_nxt = !i_hold;
          if (o_rd_en) rd_addr_nxt = o_rd_addr + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt_full) frame_cnt_nxt = o_frame_cnt + 8'd1;
      end
      default: ;
    endcase
  end

  // Output, counter and valid delay-line registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_rd_en     <= 1'b0;
      o_rd_addr   <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_frame_cnt <= '0;
      out_cnt     <= '0;
      vld_sr      <= '0;
    end else begin
      o_rd_en     <= rd_en_nxt;
      o_rd_addr   <= rd_addr_nxt;
      o_busy      <= busy_nxt;
      o_done      <= done_nxt;
      o_frame_cnt <= frame_cnt_nxt;
      out_cnt     <= out_cnt_nxt;
      vld_sr      <= (vld_sr << 1) | RD_LAT'(o_rd_en);
    end
  end

endmodule

// File: tb/tb_stage2_conv_ctrl.sv
// Testbench for stage2_conv_ctrl: random hold and core latency against a frame-level model.
// Latency: checks first-read, valid alignment, done and (optional) watchdog timing.
// Backpressure: i_hold driven randomly and as a fixed 3-cycle stall at address 37.
module tb_stage2_conv_ctrl;

  localparam int COL     = 12;
  localparam int ROW     = 12;
  localparam int K       = 5;
  localparam int RD_LAT  = 1;
  localparam int TIMEOUT = 255;
  localparam int NPIX    = COL * ROW;
  localparam int NOUT    = (COL - K + 1) * (ROW - K + 1);
  localparam int AW      = $clog2(NPIX);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_start;
  logic          i_hold;
  logic          i_core_ot_valid;
  logic          o_rd_en;
  logic [AW-1:0] o_rd_addr;
  logic          o_core_valid;
  logic          o_busy;
  logic          o_done;
  logic          o_err;
  logic [7:0]    o_frame_cnt;

  stage2_conv_ctrl #(
    .COL(COL), .ROW(ROW), .K(K), .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_start        (i_start),
    .i_hold         (i_hold),
    .o_rd_en        (o_rd_en),
    .o_rd_addr      (o_rd_addr),
    .o_core_valid   (o_core_valid),
    .i_core_ot_valid(i_core_ot_valid),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_err          (o_err),
    .o_frame_cnt    (o_frame_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // frame-level model state
  int  rd_exp, rd_cnt, first_rd, last_rd, addr_err, align_err;
  int  h37_err, h37_left, h37_chk, h37_seen;
  int  done_cnt, done_cyc, last_ot_cyc, ot_sent, in_pix, core_lat;
  int  exp_frames;
  bit  rd_en_d, drop_last, rand_hold, hold37;
  int  ot_q[$];
  bit  hold_at [32768];

  task automatic check_val(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    rd_exp = 0; rd_cnt = 0; first_rd = -1; last_rd = -1;
    addr_err = 0; align_err = 0;
    h37_err = 0; h37_left = 0; h37_chk = 0; h37_seen = 0;
    done_cnt = 0; done_cyc = -1; last_ot_cyc = -1; ot_sent = 0; in_pix = 0;
    ot_q.delete();
    i_core_ot_valid = 1'b0;
  endtask

  // One clock: core model, monitor, then drive hold for the new cycle.
  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    // conv core: a pixel completes an output window once row and col are both >= K-1
    if (o_core_valid) begin
      if ((in_pix % COL) >= K - 1 && (in_pix / COL) >= K - 1 && !(drop_last && in_pix == NPIX - 1))
        ot_q.push_back(cyc + core_lat);
      in_pix++;
    end
    i_core_ot_valid = 1'b0;
    if (ot_q.size() > 0 && ot_q[0] == cyc) begin
      i_core_ot_valid = 1'b1;
      ot_q.delete(0);
      ot_sent++;
      last_ot_cyc = cyc;
    end
    // monitor
    if (o_rd_en) begin
      if (int'(o_rd_addr) != rd_exp) addr_err++;
      rd_exp++;
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
      last_rd = cyc;
    end
    if (o_core_valid != rd_en_d) align_err++;
    rd_en_d = o_rd_en;
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (h37_chk > 0) begin
      if (o_rd_en || int'(o_rd_addr) != 37) h37_err++;
      h37_seen++;
      h37_chk--;
    end
    // hold drive
    if (hold37 && o_rd_en && int'(o_rd_addr) == 36) begin
      h37_left = 3;
      h37_chk  = 3;
    end
    i_hold = (h37_left > 0) || (rand_hold && $urandom_range(0, 5) == 0);
    if (h37_left > 0) h37_left--;
    hold_at[cyc % 32768] = i_hold;
  endtask

  task automatic run_frame(input bit hold_rand_i, input bit hold37_i, input bit spur_i, input bit drop_i);
    int start_cyc;
    int holds;
    model_clear();
    rand_hold = hold_rand_i;
    hold37    = hold37_i;
    drop_last = drop_i;
    core_lat  = int'($urandom_range(1, 5));
    start_cyc = cyc;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check_val("err_after_start", o_err, 0);
    check_val("busy_after_start", o_busy, 1);
    for (int n = 0; n < 2000 && done_cnt == 0; n++) begin
      if (spur_i && (n == 10 || n == 100)) i_start = 1'b1;
      tick();
      i_start = 1'b0;
    end
    i_hold = 1'b0;
    rand_hold = 1'b0;
    hold37 = 1'b0;
    check_val("done_seen", done_cnt, 1);
    holds = 0;
    if (first_rd >= 0)
      for (int c = first_rd; c < last_rd; c++) if (hold_at[c % 32768]) holds++;
    check_val("read_count", rd_cnt, NPIX);
    check_val("addr_order_errs", addr_err, 0);
    check_val("first_read_lat", first_rd - start_cyc, 1);
    check_val("read_span", last_rd - first_rd + 1, NPIX + holds);
    check_val("core_valid_align_errs", align_err, 0);
    if (hold37_i) begin
      check_val("hold37_cycles", h37_seen, 3);
      check_val("hold37_frozen_errs", h37_err, 0);
    end
    if (!drop_i) begin
      exp_frames = (exp_frames + 1) % 256;
      check_val("core_outputs", ot_sent, NOUT);
      check_val("done_lat", done_cyc - last_ot_cyc, 1);
    end else begin
      check_val("core_outputs", ot_sent, NOUT - 1);
      check_val("timeout_lat", done_cyc - last_ot_cyc, TIMEOUT + 1);
    end
    check_val("done_pulse", o_done, 1);
    check_val("frame_cnt", o_frame_cnt, exp_frames);
    check_val("err_at_done", o_err, drop_i);
  endtask

  task automatic reset_mid_frame();
    int n;
    model_clear();
    core_lat = 2;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    n = 0;
    while (!(o_rd_en && int'(o_rd_addr) == 80) && n < 1000) begin
      tick();
      n++;
    end
    check_val("reach_addr80", o_rd_addr, 80);
    reset_n = 1'b0;
    tick();
    check_val("mid_rst_rd_en", o_rd_en, 0);
    check_val("mid_rst_rd_addr", o_rd_addr, 0);
    check_val("mid_rst_core_valid", o_core_valid, 0);
    check_val("mid_rst_busy", o_busy, 0);
    check_val("mid_rst_done", o_done, 0);
    check_val("mid_rst_err", o_err, 0);
    check_val("mid_rst_frame_cnt", o_frame_cnt, 0);
    reset_n = 1'b1;
    model_clear();
    rd_en_d = 1'b0;
    exp_frames = 0;
    tick();
  endtask

  initial begin
    reset_n = 1'b0;
    i_start = 1'b0;
    i_hold = 1'b0;
    rand_hold = 1'b0;
    hold37 = 1'b0;
    drop_last = 1'b0;
    rd_en_d = 1'b0;
    core_lat = 1;
    exp_frames = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_rd_en", o_rd_en, 0);
    check_val("rst_rd_addr", o_rd_addr, 0);
    check_val("rst_core_valid", o_core_valid, 0);
    check_val("rst_busy", o_busy, 0);
    check_val("rst_done", o_done, 0);
    check_val("rst_err", o_err, 0);
    check_val("rst_frame_cnt", o_frame_cnt, 0);
    reset_n = 1'b1;
    repeat (2) tick();

    // plain frame
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) tick();
    check_val("idle_busy", o_busy, 0);
    check_val("idle_no_read", rd_cnt, NPIX);

    // stall at 37 plus random hold, spurious starts mid-frame
    run_frame(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (6) tick();
    check_val("single_done", done_cnt, 1);
    check_val("idle_no_read2", rd_cnt, NPIX);

    // back-to-back: start during DONE is ignored, start the cycle after is taken
    run_frame(1'b1, 1'b0, 1'b0, 1'b0);
    i_start = 1'b1;
    tick();
    run_frame(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();

    // reset in the middle of a frame, then a fresh frame from address 0
    reset_mid_frame();
    run_frame(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();

`ifdef ST2_CTRL_TIMEOUT_EN
    run_frame(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) tick();
    check_val("err_sticky_idle", o_err, 1);
    run_frame(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
